// File: rtl/pattern_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pattern_detector                                           |
// | Description : Serial bit-pattern detector with registered match pulse,   |
// |               overlapping/non-overlapping modes and an optional          |
// |               saturating match counter (macro PATTERN_DETECTOR_COUNT_EN).|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pattern_detector #(
  parameter int                 PAT_LEN = 2,
  parameter logic [PAT_LEN-1:0] PATTERN = 2'b01,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         a,
  input  logic                         clear,
  output logic                         y,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int                FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_y;

  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_match;

  // Match is judged on the post-shift history and post-increment fill.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_LEN-2:0], a};
    w_fill_inc = (r_fill == C_FULL) ? r_fill : r_fill + FILL_W'(1);
    w_match    = en && !clear && (w_hist_nxt == PATTERN) && (w_fill_inc == C_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (en) begin
      r_hist <= w_hist_nxt;
      // Non-overlapping mode restarts the fill so no matched bit is reused.
      r_fill <= (w_match && (OVERLAP == 0)) ? '0 : w_fill_inc;
      r_y    <= w_match;
    end else begin
      r_y    <= 1'b0;
    end
  end

  assign y    = r_y;
  assign fill = r_fill;

`ifdef PATTERN_DETECTOR_COUNT_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector.sv
`default_nettype none
// Self-checking bench for pattern_detector: three configurations share one
// stimulus stream and are compared against a stream-level reference model.
module tb_pattern_detector;

  logic clk = 1'b0;
  logic rst, en, a, clear;
  always #5 clk = ~clk;

  logic       y0, y1, y2;
  logic [1:0] f0;
  logic [2:0] f1, f2;
  logic [7:0] c0;
  logic [1:0] c1;
  logic [7:0] c2;

  pattern_detector #(.PAT_LEN(2), .PATTERN(2'b01), .OVERLAP(1), .CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .clear(clear), .y(y0), .fill(f0), .match_cnt(c0));
  pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) u_ov (
    .clk(clk), .rst(rst), .en(en), .a(a), .clear(clear), .y(y1), .fill(f1), .match_cnt(c1));
  pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .a(a), .clear(clear), .y(y2), .fill(f2), .match_cnt(c2));

  logic        act_y[3];
  logic [15:0] act_fill[3];
  logic [15:0] act_cnt[3];
  assign act_y[0] = y0;  assign act_fill[0] = 16'(f0);  assign act_cnt[0] = 16'(c0);
  assign act_y[1] = y1;  assign act_fill[1] = 16'(f1);  assign act_cnt[1] = 16'(c1);
  assign act_y[2] = y2;  assign act_fill[2] = 16'(f2);  assign act_cnt[2] = 16'(c2);

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pattern length, pattern value, overlap mode, counter max.
  int L[3]    = '{2, 4, 4};
  int PAT[3]  = '{1, 11, 11};
  bit OV[3]   = '{1'b1, 1'b1, 1'b0};
  int CMAX[3] = '{255, 3, 255};
  int m_hist[3];
  int m_seen[3];
  int m_cnt[3];
  bit m_y[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = 0; m_seen[k] = 0; m_cnt[k] = 0; m_y[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge(bit e, bit b, bit c);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_hist[k] = 0; m_seen[k] = 0; m_cnt[k] = 0; m_y[k] = 1'b0;
      end else if (e) begin
        m_hist[k] = ((m_hist[k] * 2) + int'(b)) % 65536;
        m_seen[k] = m_seen[k] + 1;
        m_y[k] = (m_seen[k] >= L[k]) && ((m_hist[k] % (1 << L[k])) == PAT[k]);
        if (m_y[k]) begin
          if (m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
          if (!OV[k]) m_seen[k] = 0;
        end
      end else begin
        m_y[k] = 1'b0;
      end
    end
  endfunction

  function automatic logic [15:0] exp_fill(int k);
    return 16'((m_seen[k] < L[k]) ? m_seen[k] : L[k]);
  endfunction

  function automatic logic [15:0] exp_cnt(int k);
`ifdef PATTERN_DETECTOR_COUNT_EN
    return 16'(m_cnt[k]);
`else
    return 16'(0);
`endif
  endfunction

  task automatic step(input bit e, input bit b, input bit c);
    @(negedge clk);
    en = e; a = b; clear = c;
    model_edge(e, b, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; a = 1'b0; clear = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (act_y[k] !== 1'b0) begin n_fail++; $display("FAIL reset_y[%0d]: got %b expected 0", k, act_y[k]); end
      n_checks++; if (act_fill[k] !== 16'd0) begin n_fail++; $display("FAIL reset_fill[%0d]: got %0d expected 0", k, act_fill[k]); end
      n_checks++; if (act_cnt[k] !== 16'd0) begin n_fail++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", k, act_cnt[k]); end
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_basic();
    bit seq[2] = '{1'b0, 1'b1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, seq[i], 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (act_y[k] !== m_y[k]) begin n_fail++; $display("FAIL basic_y[%0d] s%0d: got %b expected %b", k, i, act_y[k], m_y[k]); end
        n_checks++; if (act_fill[k] !== exp_fill(k)) begin n_fail++; $display("FAIL basic_fill[%0d] s%0d: got %0d expected %0d", k, i, act_fill[k], exp_fill(k)); end
      end
    end
    n_checks++; if (y0 !== 1'b1 || f0 !== 2'd2) begin n_fail++; $display("FAIL basic_p2_match: got y=%b fill=%0d expected y=1 fill=2", y0, f0); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (y0 !== 1'b0) begin n_fail++; $display("FAIL basic_p2_pulse_width: got %b expected 0", y0); end
  endtask

  task automatic test_overlap();
    bit seq[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq[i], 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (act_y[k] !== m_y[k]) begin n_fail++; $display("FAIL overlap_y[%0d] s%0d: got %b expected %b", k, i, act_y[k], m_y[k]); end
        n_checks++; if (act_fill[k] !== exp_fill(k)) begin n_fail++; $display("FAIL overlap_fill[%0d] s%0d: got %0d expected %0d", k, i, act_fill[k], exp_fill(k)); end
        n_checks++; if (act_cnt[k] !== exp_cnt(k)) begin n_fail++; $display("FAIL overlap_cnt[%0d] s%0d: got %0d expected %0d", k, i, act_cnt[k], exp_cnt(k)); end
      end
    end
    n_checks++; if (f2 !== 3'd3) begin n_fail++; $display("FAIL nonoverlap_end_fill: got %0d expected 3", f2); end
  endtask

  task automatic test_stall();
    bit seq[3] = '{1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, seq[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (act_y[k] !== m_y[k]) begin n_fail++; $display("FAIL stall_y[%0d] c%0d: got %b expected %b", k, i, act_y[k], m_y[k]); end
        n_checks++; if (act_fill[k] !== exp_fill(k)) begin n_fail++; $display("FAIL stall_fill[%0d] c%0d: got %0d expected %0d", k, i, act_fill[k], exp_fill(k)); end
      end
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++; if (y1 !== 1'b1 || y2 !== 1'b1) begin n_fail++; $display("FAIL stall_final_match: got y1=%b y2=%b expected 1 1", y1, y2); end
  endtask

  task automatic test_async_reset();
    bit seq[3] = '{1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, seq[i], 1'b0);
    #2;
    rst = 1'b0; en = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (act_fill[k] !== 16'd0) begin n_fail++; $display("FAIL async_fill[%0d]: got %0d expected 0", k, act_fill[k]); end
      n_checks++; if (act_y[k] !== 1'b0) begin n_fail++; $display("FAIL async_y[%0d]: got %b expected 0", k, act_y[k]); end
    end
    @(negedge clk) rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (act_y[k] !== m_y[k]) begin n_fail++; $display("FAIL async_after_y[%0d]: got %b expected %b", k, act_y[k], m_y[k]); end
      n_checks++; if (act_fill[k] !== exp_fill(k)) begin n_fail++; $display("FAIL async_after_fill[%0d]: got %0d expected %0d", k, act_fill[k], exp_fill(k)); end
    end
  endtask

  task automatic test_saturate_clear();
    bit seq[16] = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_checks++; if (act_cnt[1] !== exp_cnt(1)) begin n_fail++; $display("FAIL sat_cnt s%0d: got %0d expected %0d", i, act_cnt[1], exp_cnt(1)); end
    end
`ifdef PATTERN_DETECTOR_COUNT_EN
    n_checks++; if (c1 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_final: got %0d expected 3", c1); end
`endif
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (act_cnt[k] !== 16'd0) begin n_fail++; $display("FAIL clear_cnt[%0d]: got %0d expected 0", k, act_cnt[k]); end
      n_checks++; if (act_y[k] !== 1'b0) begin n_fail++; $display("FAIL clear_y[%0d]: got %b expected 0", k, act_y[k]); end
      n_checks++; if (act_fill[k] !== 16'd0) begin n_fail++; $display("FAIL clear_fill[%0d]: got %0d expected 0", k, act_fill[k]); end
    end
  endtask

  task automatic test_random();
    bit e, b, c;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 59) == 0);
      step(e, b, c);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (act_y[k] !== m_y[k]) begin n_fail++; $display("FAIL rand_y[%0d] i%0d: got %b expected %b", k, i, act_y[k], m_y[k]); end
        n_checks++; if (act_fill[k] !== exp_fill(k)) begin n_fail++; $display("FAIL rand_fill[%0d] i%0d: got %0d expected %0d", k, i, act_fill[k], exp_fill(k)); end
        n_checks++; if (act_cnt[k] !== exp_cnt(k)) begin n_fail++; $display("FAIL rand_cnt[%0d] i%0d: got %0d expected %0d", k, i, act_cnt[k], exp_cnt(k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_stall();
    test_async_reset();
    test_saturate_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 2, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 2'b01 (PAT_LEN bits wide), the bit sequence to detect; MSB is compared against the first-received bit.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match counter width, legal range 1..16.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, sample qualifier; a is consumed only on edges where en=1.
REQ-008 SHALL have port a, input, 1, serial data bit.
REQ-009 SHALL have port clear, input, 1, synchronous flush of detector state and counter.
REQ-010 SHALL have port y, output, 1, registered match pulse.
REQ-011 SHALL have port fill, output, $clog2(PAT_LEN+1), number of valid history bits held, 0..PAT_LEN.
REQ-012 SHALL have port match_cnt, output, CNT_W, saturating count of matches.

Function
REQ-013 SHALL keep a PAT_LEN-bit history; on an edge with en=1, hist shifts left by one with a entering at bit 0.
REQ-014 SHALL increment fill on each consumed sample, saturating at PAT_LEN.
REQ-015 SHALL declare a match when the post-shift hist equals PATTERN and the post-increment fill equals PAT_LEN.
REQ-016 SHALL register y: y=1 for exactly the one cycle following the edge that consumed the completing bit (Moore timing, latency 1 cycle), otherwise 0.
REQ-017 SHALL drive y=0 after any edge where en=0; hist and fill are held.
REQ-018 With OVERLAP=1, SHALL keep hist and fill after a match, so that a suffix of the match can start the next match.
REQ-019 With OVERLAP=0, SHALL set fill to 0 on the matching edge, so no bit of one match contributes to the next.
REQ-020 SHALL make clear=1 take priority over en: on that edge, hist=0, fill=0, y=0, match_cnt=0, and a is discarded.
REQ-021 Where the counter is present, SHALL increment match_cnt on each match edge, saturating at 2^CNT_W-1 (no wrap).
REQ-022 SHALL require no warm-up: the first match is reportable after exactly PAT_LEN consumed samples.

Reset
REQ-023 SHALL, while rst=0, immediately force hist=0, fill=0, y=0, match_cnt=0, independent of clk.
REQ-024 SHALL resume operation on the first rising clk edge after rst deasserts; reset mid-pattern discards all partial progress.

Configuration
REQ-025 SHALL compile in the match counter only when macro PATTERN_DETECTOR_COUNT_EN is defined.
REQ-026 When PATTERN_DETECTOR_COUNT_EN is not defined, SHALL tie match_cnt to 0, include no counter flops, and leave y and fill behaviour unchanged.

Verification
REQ-027 PAT_LEN=2, PATTERN=01: a=0,1 with en=1 -> y=1 in the cycle after the second edge only; fill=2.
REQ-028 PAT_LEN=4, PATTERN=1011, OVERLAP=1: a=1,0,1,1,0,1,1 -> y pulses after samples 4 and 7; match_cnt=2.
REQ-029 Same stimulus with OVERLAP=0 -> y pulses after sample 4 only; fill=3 at end; match_cnt=1.
REQ-030 PATTERN=1011: a=1,0,1 then en=0 for 3 cycles, then a=1 -> y=0 during stall, y=1 after the final sample.
REQ-031 PATTERN=1011: a=1,0,1, then rst=0 asynchronously mid-cycle, release, then a=1 -> fill=0 immediately at reset, no match, fill=1 at end.
REQ-032 CNT_W=2, macro defined: 5 matches -> match_cnt saturates at 3; clear=1 -> match_cnt=0, y=0 next cycle.
